mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of the ALU stage. Consumes the ALU's registered result
//  (data, store address, destination register, store flag) plus the instruction opcode.
//  Performs loads and stores over a single-outstanding req/ack data-memory port.
//  Non-memory results pass through. Produces a single write-back record per instruction.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles to wait for mem_ack before aborting with bus_err (1..65535)
//  MMIO_BASE    64'hFFFF_0000_0000_0000  addresses >= this are uncached (mem_uc=1)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  in_valid     in   1   ALU record valid
//  in_ready     out  1   stage can accept a record this cycle
//  in_opcode    in   10  {funct3,opcode[6:0]} of the instruction
//  in_data      in   64  ALU data_out: result; load address for loads; store data for stores
//  in_addr      in   64  ALU mem_out: store address (stores only)
//  in_rd        in   5   destination register
//  in_store     in   1   ALU alu_store flag
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   1=store, 0=load
//  mem_addr     out  64  byte address, 8-byte aligned (addr[2:0] zeroed)
//  mem_wdata    out  64  store data, lane-shifted
//  mem_be       out  8   byte enables
//  mem_uc       out  1   uncached access
//  mem_ack      in   1   request completed; mem_rdata valid same cycle for loads
//  mem_rdata    in   64  aligned 64-bit read word
//  wb_valid     out  1   write-back record valid (one-cycle pulse per record)
//  wb_en        out  1   write register file
//  wb_rd        out  5   destination register
//  wb_data      out  64  write-back value
//  misalign     out  1   pulse with wb_valid: access not naturally aligned, no memory access
//  bus_err      out  1   pulse with wb_valid: timeout expired
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. All outputs 0, except in_ready=1. Timeout counter=0.
//  Decode:
//   load  opcodes: 003 lb, 083 lh, 103 lw, 183 ld, 203 lbu, 283 lhu, 303 lwu.
//   store opcodes: 023 sb, 0a3 sh, 123 sw, 1a3 sd. Store is also flagged by in_store=1.
//   Any other opcode is ALU pass-through.
//  Size and alignment:
//   size from funct3[1:0]: 0=B, 1=H, 2=W, 3=D. Load address=in_data; store address=in_addr.
//   Misaligned when addr[size-1:0]!=0. Then no mem_req; record retires next cycle with
//   misalign=1, wb_en=0.
//  FSM IDLE/REQ/DONE; in_ready=1 only in IDLE. Accept when in_valid && in_ready.
//   IDLE, pass-through accepted: next cycle wb_valid=1, wb_data=in_data, wb_rd=in_rd,
//    wb_en=(in_rd!=0); stays IDLE (1-cycle latency, full throughput).
//   IDLE, aligned ld/st accepted: drive mem_* registered next cycle with mem_req=1 -> REQ.
//    mem_be = size mask << addr[2:0]; mem_wdata = store data << 8*addr[2:0].
//   REQ: mem_req and all mem_* stay stable until mem_ack; counter increments each cycle.
//    mem_ack -> drop mem_req, capture lane = mem_rdata >> 8*addr[2:0], -> DONE.
//    counter==TIMEOUT_CYC without ack -> drop mem_req, -> DONE with bus_err.
//   DONE: one cycle, wb_valid=1, -> IDLE; in_ready rises in the following cycle.
//    Load: wb_data = lane sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu/ld),
//    wb_en=(in_rd!=0). Store: wb_en=0, wb_data=0. bus_err: wb_en=0, wb_data=0.
//   Aligned load latency: accept -> wb_valid = 3 cycles with zero-wait ack (ack in 1st REQ cycle).
//  mem_ack outside REQ is ignored. in_valid while in_ready=0 is ignored; upstream holds it.
//  x0 never written: wb_en=0 whenever wb_rd==0.
//  Reset mid-REQ drops mem_req immediately (async). Any in-flight record is discarded,
//  with no wb_valid.
// TESTING
//  1 addi result 64'h5, rd=3, pass-through -> next cycle wb_valid=1, wb_en=1, wb_rd=3,
//    wb_data=5; back-to-back records retire every cycle.
//  2 lb addr 0x1003, rdata 64'h0000_0000_80FF_0000 (byte 3=0x80), ack after 2 cycles
//    -> mem_addr=0x1000, mem_be=8'h08, wb_data=64'hFFFF_FFFF_FFFF_FF80;
//    same with lbu -> 64'h80.
//  3 sh addr 0x2006, data 0xBEEF -> mem_we=1, mem_be=8'hC0, mem_wdata=64'hBEEF_0000_0000_0000,
//    wb_valid with wb_en=0.
//  4 lw addr 0x3002 -> no mem_req; next cycle wb_valid=1, misalign=1, wb_en=0.
//  5 ld with mem_ack never asserted, TIMEOUT_CYC=4 -> mem_req held exactly 4 cycles,
//    then bus_err=1 with wb_valid.
//  6 ld to rd=0 returns data -> wb_en=0. Reset asserted while in REQ -> mem_req=0 at once,
//    in_ready=1, no wb_valid.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory access stage: takes the registered ALU record, performs a single
// outstanding load or store over a req/ack data-memory port, and emits one
// write-back record per instruction. Non-memory records pass straight through.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [63:0] MMIO_BASE   = 64'hFFFF_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_opcode,
  input  logic [63:0] in_data,
  input  logic [63:0] in_addr,
  input  logic [4:0]  in_rd,
  input  logic        in_store,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  output logic        mem_uc,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value allowed in REQ; reaching it without an ack aborts.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      r_state, w_stateNext;
  logic [15:0] r_cnt, w_cntNext;
  logic [4:0]  r_rd, w_rdNext;
  logic [2:0]  r_funct3, w_funct3Next;
  logic        r_isLoad, w_isLoadNext;
  logic [2:0]  r_off, w_offNext;
  logic [63:0] r_lane, w_laneNext;
  logic        r_err, w_errNext;

  logic        w_memReqNext, w_memWeNext, w_memUcNext;
  logic [63:0] w_memAddrNext, w_memWdataNext;
  logic [7:0]  w_memBeNext;
  logic        w_wbValidNext, w_wbEnNext, w_misalignNext, w_busErrNext;
  logic [4:0]  w_wbRdNext;
  logic [63:0] w_wbDataNext;

  logic [2:0]  w_funct3;
  logic [6:0]  w_major;
  logic        w_isStore, w_isLoad;
  logic [63:0] w_addr;
  logic [5:0]  w_shift;
  logic        w_misaligned;
  logic [7:0]  w_sizeMask;
  logic [63:0] w_loadValue;

  // Instruction decode: a store is recognised by opcode or by the ALU store flag.
  assign w_funct3  = in_opcode[9:7];
  assign w_major   = in_opcode[6:0];
  assign w_isStore = in_store || ((w_major == 7'h23) && !w_funct3[2]);
  assign w_isLoad  = !w_isStore && (w_major == 7'h03) && (w_funct3 != 3'd7);
  assign w_addr    = w_isStore ? in_addr : in_data;
  assign w_shift   = {w_addr[2:0], 3'b000};
  assign in_ready  = (r_state == IDLE);

  // Access size from funct3[1:0]: byte mask and natural-alignment check.
  always_comb begin
    w_sizeMask   = 8'h01;
    w_misaligned = 1'b0;
    case (w_funct3[1:0])
      2'd0: begin w_sizeMask = 8'h01; w_misaligned = 1'b0;          end
      2'd1: begin w_sizeMask = 8'h03; w_misaligned = w_addr[0];      end
      2'd2: begin w_sizeMask = 8'h0F; w_misaligned = |w_addr[1:0];   end
      default: begin w_sizeMask = 8'hFF; w_misaligned = |w_addr[2:0]; end
    endcase
  end

  // Sign or zero extension of the captured load lane by load flavour.
  always_comb begin
    w_loadValue = r_lane;
    case (r_funct3)
      3'd0: w_loadValue = {{56{r_lane[7]}},  r_lane[7:0]};
      3'd1: w_loadValue = {{48{r_lane[15]}}, r_lane[15:0]};
      3'd2: w_loadValue = {{32{r_lane[31]}}, r_lane[31:0]};
      3'd4: w_loadValue = {56'd0, r_lane[7:0]};
      3'd5: w_loadValue = {48'd0, r_lane[15:0]};
      3'd6: w_loadValue = {32'd0, r_lane[31:0]};
      default: w_loadValue = r_lane;
    endcase
  end

  // Next-state and next-output logic; every output is registered so each record
  // leaves the stage on a clean edge.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_rdNext       = r_rd;
    w_funct3Next   = r_funct3;
    w_isLoadNext   = r_isLoad;
    w_offNext      = r_off;
    w_laneNext     = r_lane;
    w_errNext      = r_err;
    w_memReqNext   = 1'b0;
    w_memWeNext    = 1'b0;
    w_memAddrNext  = '0;
    w_memWdataNext = '0;
    w_memBeNext    = '0;
    w_memUcNext    = 1'b0;
    w_wbValidNext  = 1'b0;
    w_wbEnNext     = 1'b0;
    w_wbRdNext     = '0;
    w_wbDataNext   = '0;
    w_misalignNext = 1'b0;
    w_busErrNext   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_isLoad || w_isStore) begin
            if (w_misaligned) begin
              w_wbValidNext  = 1'b1;
              w_misalignNext = 1'b1;
              w_wbRdNext     = in_rd;
            end else begin
              w_memReqNext   = 1'b1;
              w_memWeNext    = w_isStore;
              w_memAddrNext  = {w_addr[63:3], 3'b000};
              w_memWdataNext = w_isStore ? (in_data << w_shift) : 64'd0;
              w_memBeNext    = w_sizeMask << w_addr[2:0];
              w_memUcNext    = (w_addr >= MMIO_BASE);
              w_cntNext      = '0;
              w_rdNext       = in_rd;
              w_funct3Next   = w_funct3;
              w_isLoadNext   = w_isLoad;
              w_offNext      = w_addr[2:0];
              w_laneNext     = '0;
              w_errNext      = 1'b0;
              w_stateNext    = REQ;
            end
          end else begin
            w_wbValidNext = 1'b1;
            w_wbEnNext    = (in_rd != 5'd0);
            w_wbRdNext    = in_rd;
            w_wbDataNext  = in_data;
          end
        end
      end
      REQ: begin
        w_cntNext = r_cnt + 16'd1;
        if (mem_ack) begin
          w_laneNext  = mem_rdata >> {r_off, 3'b000};
          w_stateNext = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_errNext   = 1'b1;
          w_stateNext = DONE;
        end else begin
          w_memReqNext   = mem_req;
          w_memWeNext    = mem_we;
          w_memAddrNext  = mem_addr;
          w_memWdataNext = mem_wdata;
          w_memBeNext    = mem_be;
          w_memUcNext    = mem_uc;
        end
      end
      DONE: begin
        w_wbValidNext = 1'b1;
        w_wbRdNext    = r_rd;
        w_busErrNext  = r_err;
        if (!r_err && r_isLoad) begin
          w_wbEnNext   = (r_rd != 5'd0);
          w_wbDataNext = w_loadValue;
        end
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State, context and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_isLoad  <= 1'b0;
      r_off     <= '0;
      r_lane    <= '0;
      r_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_uc    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_rd      <= w_rdNext;
      r_funct3  <= w_funct3Next;
      r_isLoad  <= w_isLoadNext;
      r_off     <= w_offNext;
      r_lane    <= w_laneNext;
      r_err     <= w_errNext;
      mem_req   <= w_memReqNext;
      mem_we    <= w_memWeNext;
      mem_addr  <= w_memAddrNext;
      mem_wdata <= w_memWdataNext;
      mem_be    <= w_memBeNext;
      mem_uc    <= w_memUcNext;
      wb_valid  <= w_wbValidNext;
      wb_en     <= w_wbEnNext;
      wb_rd     <= w_wbRdNext;
      wb_data   <= w_wbDataNext;
      misalign  <= w_misalignNext;
      bus_err   <= w_busErrNext;
    end
  end

endmodule
